// File: rtl/packet_streamer_if.sv
// Frame FIFO read side and streaming output side of packet_streamer.
// master is the streamer's view; slave is the FIFO/sink side.
interface packet_streamer_if;
   logic [31:0] fifo_q;
   logic        fifo_eop;
   logic [1:0]  fifo_empty;
   logic        fifo_rdempty;
   logic        fifo_rdreq;
   logic        ready;
   logic [31:0] data_out;
   logic        valid;
   logic        sop;
   logic        eop;
   logic [1:0]  empty;
   logic        error;
   logic [31:0] pkt_count;
   logic [31:0] err_count;

   modport master (
      input  fifo_q, fifo_eop, fifo_empty, fifo_rdempty, ready,
      output fifo_rdreq, data_out, valid, sop, eop, empty, error,
      output pkt_count, err_count
   );

   modport slave (
      output fifo_q, fifo_eop, fifo_empty, fifo_rdempty, ready,
      input  fifo_rdreq, data_out, valid, sop, eop, empty, error,
      input  pkt_count, err_count
   );
endinterface

// File: rtl/packet_streamer.sv
// Replays tagged frames from a show-ahead FIFO as a 32-bit stream,
// truncating oversize frames with error and flushing their tail.
module packet_streamer #(
   parameter int unsigned MAX_WORDS = 380
) (
   input  logic              clk,
   input  logic              n_rst,
   packet_streamer_if.master st
);

   localparam logic [9:0] MAX_W = 10'(MAX_WORDS);

   typedef enum logic [1:0] {IDLE, BODY, DROP} state_t;

   state_t      state_q, state_d;
   logic [9:0]  cnt_q, cnt_d, cnt_new;
   logic        load, accept, drop_pop;
   logic [31:0] data_q;
   logic        valid_q, sop_q, eop_q, err_q;
   logic [1:0]  empty_q;
   logic [31:0] pkt_q, errc_q;

   assign load     = n_rst && !st.fifo_rdempty
                   && (!valid_q || st.ready) && state_q != DROP;
   assign drop_pop = n_rst && !st.fifo_rdempty && state_q == DROP;
   assign accept   = valid_q && st.ready;
   assign cnt_new  = (state_q == IDLE) ? 10'd1 : cnt_q + 10'd1;

   assign st.fifo_rdreq = load || drop_pop;
   assign st.data_out   = data_q;
   assign st.valid      = valid_q;
   assign st.sop        = sop_q;
   assign st.eop        = eop_q;
   assign st.empty      = empty_q;
   assign st.error      = err_q;
   assign st.pkt_count  = pkt_q;
   assign st.err_count  = errc_q;

   // State and word counter registers
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Frame tracking: start, body, truncation and tail flush
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE, BODY: begin
            if (load) begin
               cnt_d = cnt_new;
               if (st.fifo_eop)
                  state_d = IDLE;
               else if (cnt_new == MAX_W)
                  state_d = DROP;
               else
                  state_d = BODY;
            end
         end
         DROP: begin
            if (drop_pop && st.fifo_eop) begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Output beat register: load a new word or retire the accepted one
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         data_q  <= '0;
         valid_q <= 1'b0;
         sop_q   <= 1'b0;
         eop_q   <= 1'b0;
         empty_q <= '0;
         err_q   <= 1'b0;
      end else if (load) begin
         data_q  <= st.fifo_q;
         valid_q <= 1'b1;
         sop_q   <= (state_q == IDLE);
         if (st.fifo_eop) begin
            eop_q   <= 1'b1;
            empty_q <= st.fifo_empty;
            err_q   <= 1'b0;
         end else if (cnt_new == MAX_W) begin
            eop_q   <= 1'b1;
            empty_q <= '0;
            err_q   <= 1'b1;
         end else begin
            eop_q   <= 1'b0;
            empty_q <= '0;
            err_q   <= 1'b0;
         end
      end else if (accept) begin
         valid_q <= 1'b0;
      end
   end

   // Completed and truncated frame counters
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         pkt_q  <= '0;
         errc_q <= '0;
      end else if (accept && eop_q) begin
         pkt_q <= pkt_q + 32'd1;
         if (err_q)
            errc_q <= errc_q + 32'd1;
      end
   end

endmodule

// File: doc/packet_streamer.md
# packet_streamer

Streaming-interface source that emits Ethernet frames one 32-bit word per beat. It drains a show-ahead frame FIFO whose words carry end-of-frame tags, and drives sop/eop/valid/empty/error toward a downstream receiver under ready backpressure. It is the transmit-side counterpart of the sniffer's receive path and is used to replay frames into the sniffer. Frames longer than MAX_WORDS are truncated with error and the FIFO is flushed up to the frame's tagged end.

## Interface
- MAX_WORDS, 380, maximum beats per frame (1518 bytes / 4, rounded up); legal range 2..1023
- clk  in  1  clock, all state on rising edge
- n_rst  in  1  asynchronous active-low reset
- fifo_q  in  32  head word of show-ahead FIFO, valid whenever fifo_rdempty=0
- fifo_eop  in  1  head word is last word of its frame
- fifo_empty  in  2  unused byte count of head word; meaningful only with fifo_eop=1
- fifo_rdempty  in  1  FIFO has no words
- fifo_rdreq  out  1  pop head word this cycle (combinational)
- ready  in  1  downstream accepts a beat this cycle (ready latency 0)
- data_out  out  32  beat data
- valid  out  1  beat present
- sop  out  1  first beat of frame
- eop  out  1  last beat of frame
- empty  out  2  unused bytes in eop beat; 0 otherwise
- error  out  1  frame truncated; asserted only with eop
- pkt_count  out  32  frames completed (eop beat accepted)
- err_count  out  32  truncated frames completed

## Operation
- One output register (data_out/sop/eop/empty/error/valid). A beat transfers when valid=1 and ready=1.
- Load condition: `load = !fifo_rdempty && (!valid || ready) && state != DROP`. fifo_rdreq = load in IDLE/BODY, and fifo_rdreq = !fifo_rdempty in DROP.
- On load: data_out←fifo_q, valid←1, sop←(state==IDLE), and word_cnt (10 bits) updates to 1 in IDLE or to word_cnt+1 in BODY.
- When valid=1, ready=1 and no load occurs, valid←0. All other output fields keep their last values.
- While valid=1 and ready=0, every output field is held stable.
- States:
  - IDLE: next loaded word starts a frame.
  - BODY: inside a frame.
  - DROP: discarding the remainder of an oversize frame.
- Transitions on load:
  - fifo_eop=1: eop←1, empty←fifo_empty, error←0, state→IDLE. A single-word frame therefore has sop=eop=1.
  - fifo_eop=0 and new word_cnt==MAX_WORDS: eop←1, error←1, empty←0, state→DROP.
  - otherwise: eop←0, empty←0, error←0, state→BODY.
- DROP: pops every available word without emitting it. On popping a word with fifo_eop=1, state→IDLE and word_cnt←0.
- Counters: pkt_count increments on each accepted eop beat; err_count also increments if error=1. Both wrap modulo 2^32. They are never cleared except by reset.

## Timing
- Reset (async assert, sync release): state=IDLE, word_cnt=0, valid=sop=eop=error=0, data_out=0, empty=0, pkt_count=err_count=0. fifo_rdreq=0 while n_rst=0.
- Latency: FIFO word present with a free/draining output register → valid on the next edge. Back-to-back throughput is 1 word/cycle with ready held 1, including across frame boundaries (no idle beat between eop and the next sop).
- ready deasserted: no pop and no output change. ready reasserted: the held beat transfers on that edge, and a new word loads on the same edge if one is available.
- fifo_rdempty mid-frame: valid drops after the last beat is accepted. The frame resumes in BODY with sop=0 when data returns. No timeout.
- Truncation boundary: the word at count MAX_WORDS carrying fifo_eop=1 is a legal frame (no error). Truncation applies only when word MAX_WORDS lacks the tag.
- Reset mid-frame: all state is discarded. The next word is treated as sop even if it belongs to the prior frame.

## Test plan
- Reset, then one frame of 3 words (A1,A2,A3; eop on A3, fifo_empty=2), ready=1 → beats on 3 consecutive cycles: sop only on A1, eop and empty=2 on A3, pkt_count=1.
- Single-word frame 0xDEADBEEF with eop, fifo_empty=0 → one beat with sop=eop=1 and error=0.
- Two back-to-back 2-word frames, ready=1 → 4 consecutive valid beats, sop on beats 1 and 3, eop on beats 2 and 4, pkt_count=2.
- 4-word frame with ready=0 on cycles 2–4 after first valid → data_out/sop/eop held constant while stalled, each word delivered exactly once, fifo_rdreq=0 while stalled.
- MAX_WORDS=4, 7-word frame (eop on word 7) followed by 1-word frame B → beats W1..W4 with eop=error=1 on W4; W5..W7 popped and not emitted; B emitted with sop=eop=1; pkt_count=2, err_count=1.
- MAX_WORDS=4, 4-word frame with eop on word 4 → error=0, err_count=0. Assert n_rst mid-frame → all outputs 0 immediately.
